// File: rtl/dataflow_pkg.sv
// Inter-stage record types and the fetch state encoding for the 5-stage core.
package dataflow_pkg;

  localparam int DataSize = 32;

  typedef struct packed {
    logic [DataSize-1:0] pc;
    logic [DataSize-1:0] pc_plus_4;
    logic [31:0]         inst;
  } if_id_t;

  typedef enum logic [1:0] {
    Idle,
    Wait,
    Drop
  } fetch_state_t;

endpackage

// File: rtl/instruction_pkg.sv
// Instruction-encoding constants shared by the front end of the core.
package instruction_pkg;

  localparam logic [31:0] NopInstruction = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with clear; head entry is visible combinationally.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] head_data,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Storage is plain data: no reset, and a cleared push never lands.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CntW'(Depth));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one memory request outstanding and
// buffers fetched words for Decode; flush redirects and squashes in-flight work.
module fetch_stage
  import dataflow_pkg::*;
  import instruction_pkg::*;
#(
  parameter logic [DataSize-1:0] ResetPc   = '0,
  parameter int                  FifoDepth = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                inst_mem_en,
  output logic [DataSize-1:0] inst_mem_addr,
  input  logic                inst_mem_ack,
  input  logic [31:0]         inst_mem_rd_dat,
  input  logic                stall,
  input  logic                flush,
  input  logic [DataSize-1:0] flush_pc,
  output if_id_t              if_id,
  output logic                if_id_valid
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  fetch_state_t        state, state_nxt;
  logic [DataSize-1:0] fetch_pc, fetch_pc_nxt;
  logic [DataSize-1:0] drop_pc, drop_pc_nxt;
  logic [DataSize-1:0] addr_sel;
  logic [CntW-1:0]     count;
  logic [CntW-1:0]     count_after_push;
  logic                fifo_full, fifo_empty;
  logic                push, pop, space, ack_wait;
  if_id_t              push_rec, head_rec;

  assign pop              = if_id_valid && !stall;
  assign space            = !fifo_full || pop;
  assign ack_wait         = inst_mem_ack && (state == Wait);
  assign push             = ack_wait && !flush;
  assign count_after_push = count + CntW'(1) - CntW'(pop);
  assign push_rec         = '{pc:        fetch_pc,
                              pc_plus_4: fetch_pc + DataSize'(4),
                              inst:      inst_mem_rd_dat};

  sync_fifo #(
    .Width($bits(if_id_t)),
    .Depth(FifoDepth)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .pop      (pop),
    .push_data(push_rec),
    .head_data(head_rec),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_pc_nxt  = drop_pc;
    if (flush) begin
      fetch_pc_nxt = {flush_pc[DataSize-1:2], 2'b00};
      // An unanswered request must still complete on the bus at its old address.
      if (state != Idle && !inst_mem_ack) begin
        state_nxt = Drop;
        if (state == Wait) drop_pc_nxt = fetch_pc;
      end else begin
        state_nxt = Wait;
      end
    end else begin
      unique case (state)
        Idle: if (space) state_nxt = Wait;
        Wait: begin
          if (inst_mem_ack) begin
            fetch_pc_nxt = fetch_pc + DataSize'(4);
            state_nxt    = (count_after_push < CntW'(FifoDepth)) ? Wait : Idle;
          end
        end
        Drop: if (inst_mem_ack) state_nxt = Wait;
        default: state_nxt = Idle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= Idle;
      fetch_pc <= ResetPc;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clock) begin
    drop_pc <= drop_pc_nxt;
  end

  assign addr_sel      = (state == Drop) ? drop_pc : fetch_pc;
  assign inst_mem_en   = (state != Idle);
  assign inst_mem_addr = {addr_sel[DataSize-1:2], 2'b00};
  assign if_id_valid   = !fifo_empty;
  assign if_id         = if_id_valid ? head_rec
                                     : '{pc: '0, pc_plus_4: '0, inst: NopInstruction};

endmodule
